// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int UART_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources,
// holding the grant for a packet and pacing bytes on tx_active_i.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int START_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_vld_i,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_rdy_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic [UART_DATA_W-1:0]         tx_data_o,
  output logic                           tx_data_vld_o,
  input  logic                           tx_active_i,
  output logic                           busy_o,
  output logic                           timeout_err_o,
  output logic [1:0]                     state_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (START_TIMEOUT > LOCK_TIMEOUT) ? START_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [CNT_W-1:0]   START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   last_q, last_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_vld_q, tx_vld_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       next_ptr;
  logic                   sel_vld;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (req_vld_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx_q == IDX_W'(k)) begin
        sel_vld  = req_vld_i[k];
        sel_last = req_last_i[k];
        sel_data = req_data_i[k*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  assign next_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  // Handshake: a byte moves on a cycle where req_vld_i[g] and req_rdy_o[g] are both 1.
  // Ready is only offered by the owner, in LOAD, while the transmitter is idle.
  assign req_rdy_o = (state_q == LOAD && !tx_active_i) ? (grant_q & req_vld_i) : '0;
  assign busy_o    = (state_q != IDLE);
  assign state_o   = state_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_vld_i) begin
          gidx_d  = arb_idx;
          grant_d = arb_gnt;
          burst_d = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_vld && !tx_active_i) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          burst_d   = burst_q + BURST_W'(1);
          tx_vld_d  = 1'b1;
          cnt_d     = '0;
          state_d   = START;
        end else if (!sel_vld) begin
          if (cnt_q == LOCK_LAST) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      START: begin
        if (tx_active_i) begin
          state_d = DONE;
        end else if (cnt_q == START_LAST) begin
          // Dead transmitter: drop the packet and let others in.
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (!tx_active_i) begin
          if (last_q || burst_q == BURST_MAX) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
    end
  end

  assign grant_o       = grant_q;
  assign tx_data_o     = tx_data_q;
  assign tx_data_vld_o = tx_vld_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester queues, a UART busy model and a byte scoreboard.
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int N = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_vld, req_last;
  logic [N*8-1:0] req_data;
  logic           tx_active;

  logic [N-1:0] rdy_a, gnt_a, rdy_b, gnt_b;
  logic [7:0]   txd_a, txd_b;
  logic         vld_a, busy_a, err_a, vld_b, busy_b, err_b;
  logic [1:0]   st_a, st_b;

  uart_tx_sched dut (
    .clk_i(clk), .rst_i(rst), .req_vld_i(req_vld), .req_data_i(req_data),
    .req_last_i(req_last), .req_rdy_o(rdy_a), .grant_o(gnt_a), .tx_data_o(txd_a),
    .tx_data_vld_o(vld_a), .tx_active_i(tx_active), .busy_o(busy_a),
    .timeout_err_o(err_a), .state_o(st_a)
  );

  uart_tx_sched #(.MAX_BURST(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_vld_i(req_vld), .req_data_i(req_data),
    .req_last_i(req_last), .req_rdy_o(rdy_b), .grant_o(gnt_b), .tx_data_o(txd_b),
    .tx_data_vld_o(vld_b), .tx_active_i(tx_active), .busy_o(busy_b),
    .timeout_err_o(err_b), .state_o(st_b)
  );

  bit use_b = 1'b0;
  bit uart_dead = 1'b0;

  logic [N-1:0] obs_rdy, obs_gnt;
  logic [7:0]   obs_txd;
  logic         obs_vld, obs_busy, obs_err;
  logic [1:0]   obs_state;
  assign obs_rdy   = use_b ? rdy_b  : rdy_a;
  assign obs_gnt   = use_b ? gnt_b  : gnt_a;
  assign obs_txd   = use_b ? txd_b  : txd_a;
  assign obs_vld   = use_b ? vld_b  : vld_a;
  assign obs_busy  = use_b ? busy_b : busy_a;
  assign obs_err   = use_b ? err_b  : err_a;
  assign obs_state = use_b ? st_b   : st_a;

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rr_ptr();
    return use_b ? int'(dut_b.rr_ptr_q) : int'(dut.rr_ptr_q);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [N-1:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = N - 1; k >= 0; k--) if (g[k]) r = 2'(k);
    return r;
  endfunction

  // requester sources
  logic [8:0] src_mem[N][16];
  int src_head[N];
  int src_tail[N];

  task automatic push_byte(input int k, input logic [7:0] d, input logic last);
    src_mem[k][src_tail[k]] = {last, d};
    src_tail[k]++;
  endtask

  function automatic bit src_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < N; k++) if (src_head[k] != src_tail[k]) e = 1'b0;
    return e;
  endfunction

  // monitors
  int cyc = 0;
  int start_dly, act_left;
  int pulse_cnt, err_cnt, vld_cyc, err_cyc, vld_rise_cyc, grant_rise_cyc;
  int grant_fall_cyc, load_cyc, rdy_viol;
  logic [N-1:0] acc, prev_gnt, prev_vld;
  logic [1:0]   prev_state;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc <= rst ? '0 : obs_rdy;
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) if (acc[k] && src_head[k] != src_tail[k]) src_head[k]++;
    if (obs_vld) begin
      pulse_cnt++;
      vld_cyc = cyc;
      if (exp_q.size() == 0) check("sb_unexpected_byte", {22'd0, onehot_idx(obs_gnt), obs_txd}, 32'hFFFF);
      else check("sb_byte", {22'd0, onehot_idx(obs_gnt), obs_txd}, {22'd0, exp_q.pop_front()});
    end
    if (obs_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (obs_gnt != '0 && prev_gnt == '0) grant_rise_cyc = cyc;
    if (obs_gnt == '0 && prev_gnt != '0) grant_fall_cyc = cyc;
    if ((obs_rdy & ~obs_gnt) != '0 || $countones(obs_rdy) > 1) rdy_viol++;
    if (prev_state == DONE && obs_state == LOAD) load_cyc = cyc;
    prev_gnt   = obs_gnt;
    prev_state = obs_state;
    // UART model: busy from 3 cycles after the start pulse, for 20 cycles
    if (start_dly > 0) begin
      start_dly--;
      if (start_dly == 0) begin
        tx_active = 1'b1;
        act_left  = 20;
      end
    end else if (act_left > 0) begin
      act_left--;
      if (act_left == 0) tx_active = 1'b0;
    end
    if (obs_vld && !uart_dead) start_dly = 3;
    // drive requesters
    for (int k = 0; k < N; k++) begin
      req_vld[k] = (src_head[k] != src_tail[k]);
      req_data[k*8 +: 8] = src_mem[k][src_head[k] % 16][7:0];
      req_last[k] = src_mem[k][src_head[k] % 16][8];
    end
    if (req_vld != '0 && prev_vld == '0) vld_rise_cyc = cyc;
    prev_vld = req_vld;
  end

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      src_head[k] = 0;
      src_tail[k] = 0;
      for (int j = 0; j < 16; j++) src_mem[k][j] = '0;
    end
    exp_q.delete();
    start_dly = 0; act_left = 0; tx_active = 1'b0;
    pulse_cnt = 0; err_cnt = 0; vld_cyc = 0; err_cyc = 0; vld_rise_cyc = 0;
    grant_rise_cyc = 0; grant_fall_cyc = 0; load_cyc = 0; rdy_viol = 0;
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
      done = src_empty() && !obs_busy && !tx_active;
    end
    check({tag, "_completes"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_vld = '0; req_data = '0; req_last = '0; tx_active = 1'b0;
    prev_gnt = '0; prev_vld = '0; prev_state = 2'd0;
    clear_model();
    do_reset();

    check("reset_grant", {28'd0, obs_gnt}, 32'd0);
    check("reset_txd", {24'd0, obs_txd}, 32'd0);
    check("reset_busy", {31'd0, obs_busy}, 32'd0);
    check("reset_rr_ptr", rr_ptr(), 32'd0);

    // 1: single byte
    push_byte(0, 8'hA5, 1'b1);
    exp_q.push_back({2'd0, 8'hA5});
    wait_done("t1", 200);
    check("t1_grant_latency", grant_rise_cyc - vld_rise_cyc, 32'd1);
    check("t1_vld_latency", vld_cyc - vld_rise_cyc, 32'd2);
    check("t1_txd", {24'd0, obs_txd}, 32'hA5);
    check("t1_pulses", pulse_cnt, 32'd1);
    check("t1_state_idle", {30'd0, obs_state}, {30'd0, IDLE});
    check("t1_rr_ptr", rr_ptr(), 32'd1);

    // 2: packet lock, req 2 waits for req 1's 3-byte packet
    do_reset();
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    push_byte(2, 8'h44, 1'b1);
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd1, 8'h22});
    exp_q.push_back({2'd1, 8'h33});
    exp_q.push_back({2'd2, 8'h44});
    wait_done("t2", 400);
    check("t2_rdy_only_owner", rdy_viol, 32'd0);
    check("t2_all_bytes", exp_q.size(), 32'd0);
    check("t2_rr_ptr", rr_ptr(), 32'd3);

    // 3: round robin over all four, wrapping back to 0
    do_reset();
    push_byte(0, 8'hA0, 1'b1);
    push_byte(0, 8'hA1, 1'b1);
    push_byte(1, 8'hB0, 1'b1);
    push_byte(2, 8'hC0, 1'b1);
    push_byte(3, 8'hD0, 1'b1);
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hB0});
    exp_q.push_back({2'd2, 8'hC0});
    exp_q.push_back({2'd3, 8'hD0});
    exp_q.push_back({2'd0, 8'hA1});
    wait_done("t3", 600);
    check("t3_all_bytes", exp_q.size(), 32'd0);
    check("t3_pulses", pulse_cnt, 32'd5);
    check("t3_rr_ptr", rr_ptr(), 32'd1);
    check("t3_rdy_onehot", rdy_viol, 32'd0);

    // 4: burst cap of 2 on the second instance
    use_b = 1'b1;
    do_reset();
    push_byte(3, 8'h31, 1'b0);
    push_byte(3, 8'h32, 1'b0);
    push_byte(3, 8'h33, 1'b0);
    push_byte(3, 8'h34, 1'b0);
    push_byte(3, 8'h35, 1'b0);
    n = 0;
    while (!obs_gnt[3] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("t4_first_grant", {28'd0, obs_gnt}, 32'h8);
    push_byte(0, 8'h01, 1'b1);
    push_byte(0, 8'h02, 1'b1);
    exp_q.push_back({2'd3, 8'h31});
    exp_q.push_back({2'd3, 8'h32});
    exp_q.push_back({2'd0, 8'h01});
    exp_q.push_back({2'd3, 8'h33});
    exp_q.push_back({2'd3, 8'h34});
    exp_q.push_back({2'd0, 8'h02});
    exp_q.push_back({2'd3, 8'h35});
    wait_done("t4", 3000);
    check("t4_all_bytes", exp_q.size(), 32'd0);
    check("t4_rr_ptr", rr_ptr(), 32'd0);
    use_b = 1'b0;

    // 5: dead transmitter
    do_reset();
    uart_dead = 1'b1;
    push_byte(2, 8'h5A, 1'b1);
    exp_q.push_back({2'd2, 8'h5A});
    wait_done("t5", 300);
    check("t5_err_delay", err_cyc - vld_cyc, 32'd64);
    check("t5_err_pulses", err_cnt, 32'd1);
    check("t5_grant", {28'd0, obs_gnt}, 32'd0);
    check("t5_state_idle", {30'd0, obs_state}, {30'd0, IDLE});
    check("t5_rr_ptr", rr_ptr(), 32'd3);
    uart_dead = 1'b0;

    // 6a: locked requester goes quiet
    do_reset();
    push_byte(1, 8'h66, 1'b0);
    exp_q.push_back({2'd1, 8'h66});
    wait_done("t6a", 1400);
    check("t6a_lock_release", grant_fall_cyc - load_cyc, 32'd1024);
    check("t6a_err_none", err_cnt, 32'd0);
    check("t6a_rr_ptr", rr_ptr(), 32'd2);

    // 6b: reset while waiting in START
    do_reset();
    uart_dead = 1'b1;
    push_byte(0, 8'h77, 1'b1);
    exp_q.push_back({2'd0, 8'h77});
    n = 0;
    while (obs_state != START && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("t6b_reached_start", {30'd0, obs_state}, {30'd0, START});
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("t6b_rst_outputs", {obs_gnt, obs_rdy, obs_txd, obs_vld, obs_busy, obs_err}, 32'd0);
    rst = 1'b0;
    uart_dead = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    check("t6b_no_err", err_cnt, 32'd0);
    check("t6b_idle", {31'd0, obs_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
